// File: rtl/serial_alu.sv
// Multi-cycle WIDTH-bit ALU that walks the operands SLICE bits per clock, LSB first.
// Carry ripples slice-to-slice through cy_q; flags and result update only on completion.

module serial_alu_bit (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [1:0] op_i,
    output logic       r_o,
    output logic       c_o
);
    always_comb begin
        unique case (op_i)
            2'b00:   r_o = a_i & b_i;
            2'b01:   r_o = a_i | b_i;
            default: r_o = a_i ^ b_i ^ c_i;
        endcase
        c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end
endmodule

module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             A_invert,
    input  logic             B_invert,
    input  logic             carry_in,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_SLT = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic [1:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [SLICE-1:0] slice_res;
    logic [SLICE:0]   cch;
    logic [WIDTH-1:0] asm_val, final_res;
    logic             last, arith, ovf_w;

    assign cch[0] = cy_q;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        serial_alu_bit u_bit (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .c_i  (cch[i]),
            .op_i (op_q),
            .r_o  (slice_res[i]),
            .c_o  (cch[i+1])
        );
    end

    // New slice enters at the top; after N shifts the LSB slice sits at bit 0.
    if (SLICE == WIDTH) begin : g_full
        assign asm_val = slice_res;
    end else begin : g_part
        assign asm_val = {slice_res, sh_q[WIDTH-1:SLICE]};
    end

    assign last      = (cnt_q == CW'(N - 1));
    assign arith     = op_q[1];
    assign ovf_w     = cch[SLICE-1] ^ cch[SLICE];
    // SLT: sign of the true difference is the sum MSB corrected by overflow.
    assign final_res = (op_q == OP_SLT) ? WIDTH'(slice_res[SLICE-1] ^ ovf_w) : asm_val;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        op_d     = op_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                sh_d  = asm_val;
                cy_d  = cch[SLICE];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                    carry_d  = arith & cch[SLICE];
                    ovf_d    = arith & ovf_w;
                    zero_d   = (final_res == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = A ^ {WIDTH{A_invert}};
                    b_d     = B ^ {WIDTH{B_invert}};
                    op_d    = op;
                    cy_d    = carry_in;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            op_q     <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            op_q     <= op_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: WIDTH=8 with SLICE=1 and SLICE=4 instances, table vectors,
// random ops against an arithmetic reference model, and handshake/reset sequences.

module tb_serial_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       ai = 1'b0, bi = 1'b0, ci = 1'b0;
    logic [1:0] op = '0;

    logic       busy1, done1, c1, z1, v1;
    logic       busy4, done4, c4, z4, v4;
    logic [7:0] r1, r4;

    int n_chk = 0, n_fail = 0, bd_viol = 0;

    always #5 clk = ~clk;

    serial_alu #(.WIDTH(8), .SLICE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(A), .B(B),
        .A_invert(ai), .B_invert(bi), .carry_in(ci), .op(op),
        .busy(busy1), .done(done1), .result(r1), .carry(c1), .zero(z1), .overflow(v1)
    );

    serial_alu #(.WIDTH(8), .SLICE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B),
        .A_invert(ai), .B_invert(bi), .carry_in(ci), .op(op),
        .busy(busy4), .done(done4), .result(r4), .carry(c4), .zero(z4), .overflow(v4)
    );

    always @(negedge clk)
        if ((busy1 && done1) || (busy4 && done4)) bd_viol++;

    typedef struct {
        logic       ai, bi, ci;
        logic [1:0] op;
        logic [7:0] a, b;
        logic [7:0] res;
        logic       c, z, v;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, signed overflow from operand/result signs.
    function automatic logic [10:0] model(input logic xai, xbi, xci, input logic [1:0] xop,
                                           input logic [7:0] xa, xb);
        logic [7:0] aa, bb, r;
        logic [8:0] s;
        logic       c, v;
        aa = xa ^ {8{xai}};
        bb = xb ^ {8{xbi}};
        s  = {1'b0, aa} + {1'b0, bb} + {8'd0, xci};
        c  = 1'b0;
        v  = 1'b0;
        case (xop)
            2'b00: r = aa & bb;
            2'b01: r = aa | bb;
            default: begin
                c = s[8];
                v = (aa[7] == bb[7]) && (s[7] != aa[7]);
                r = (xop == 2'b11) ? {7'd0, s[7] ^ v} : s[7:0];
            end
        endcase
        return {v, (r == 8'd0), c, r};
    endfunction

    function automatic logic [10:0] outs(input int sel);
        return (sel == 1) ? {v1, z1, c1, r1} : {v4, z4, c4, r4};
    endfunction

    function automatic logic dn(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction

    // lat = cycle index (cycle 1 follows the accept edge) in which done is first high, -1 on timeout.
    task automatic run_op(input int sel, input logic xai, xbi, xci, input logic [1:0] xop,
                          input logic [7:0] xa, xb, output int lat);
        @(negedge clk);
        A = xa; B = xb; ai = xai; bi = xbi; ci = xci; op = xop;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        lat = 1;
        while (!dn(sel) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!dn(sel)) lat = -1;
    endtask

    initial begin
        int         lat, nd;
        logic [10:0] exp;
        logic [7:0]  ra, rb;
        logic [1:0]  rop;
        logic        rai, rbi, rci;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2'b01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2'b11, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 2'b11, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_u1", {busy1, done1, r1, c1, z1, v1}, 0);
        chk("reset_u4", {busy4, done4, r4, c4, z4, v4}, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int s = 1; s <= 4; s += 3) begin
                run_op(s, tbl[i].ai, tbl[i].bi, tbl[i].ci, tbl[i].op, tbl[i].a, tbl[i].b, lat);
                chk($sformatf("tbl%0d_s%0d_lat", i, s), lat, (s == 1) ? 9 : 3);
                chk($sformatf("tbl%0d_s%0d_out", i, s), outs(s),
                    {tbl[i].v, tbl[i].z, tbl[i].c, tbl[i].res});
            end
        end

        for (int k = 0; k < 40; k++) begin
            for (int s = 1; s <= 4; s += 3) begin
                ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom_range(0, 3));
                rai = 1'($urandom); rbi = 1'($urandom); rci = 1'($urandom);
                exp = model(rai, rbi, rci, rop, ra, rb);
                run_op(s, rai, rbi, rci, rop, ra, rb, lat);
                chk($sformatf("rnd%0d_s%0d_lat", k, s), lat, (s == 1) ? 9 : 3);
                chk($sformatf("rnd%0d_s%0d_out", k, s), outs(s), exp);
            end
        end

        // start held high through RUN: exactly one completion
        @(negedge clk);
        A = 8'hAA; B = 8'h0F; ai = 0; bi = 0; ci = 0; op = 2'b01;
        start1 = 1'b1;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done1) begin nd++; start1 = 1'b0; end
        end
        start1 = 1'b0;
        chk("held_start_dones", nd, 1);
        chk("held_start_idle", {busy1, done1}, 0);
        chk("held_start_res", r1, 8'hAF);

        // start during DONE: accepted with no IDLE gap, old outputs held meanwhile
        run_op(1, 0, 0, 0, 2'b10, 8'hFF, 8'h01, lat);
        chk("b2b_first_lat", lat, 9);
        A = 8'h80; B = 8'h01; ai = 0; bi = 1; ci = 1; op = 2'b10;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("b2b_busy_no_gap", {busy1, done1}, 2'b10);
        chk("b2b_hold_prev", {v1, z1, c1, r1}, {1'b0, 1'b1, 1'b1, 8'h00});
        lat = 1;
        while (!done1 && lat < 64) begin @(posedge clk); #1; lat++; end
        chk("b2b_second_lat", lat, 9);
        chk("b2b_second_out", {v1, z1, c1, r1}, {1'b1, 1'b0, 1'b1, 8'h7F});

        // reset mid-RUN aborts, clears outputs, then a normal op still works
        run_op(1, 0, 0, 0, 2'b00, 8'hF0, 8'h3C, lat);
        @(negedge clk);
        A = 8'h05; B = 8'h07; ai = 0; bi = 0; ci = 0; op = 2'b10;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_run_busy", busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy1, done1, r1, c1, z1, v1}, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (12) begin @(posedge clk); #1; if (done1) nd++; end
        chk("abort_no_done", nd, 0);
        run_op(1, 0, 0, 0, 2'b10, 8'h05, 8'h07, lat);
        chk("after_abort_lat", lat, 9);
        chk("after_abort_out", {v1, z1, c1, r1}, {1'b0, 1'b0, 1'b0, 8'h0C});

        chk("busy_done_exclusive", bd_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
